// File: rtl/ay_bus_master.sv
// AY-slot bus initiator: turns req/op/wdata into timed BDIR/BC1/BC2 bus cycles.
// Define AY_BUS_MASTER_VERIFY_EN to add an automatic readback after every data write.
module ay_bus_master #(
  parameter int unsigned T_SETUP = 3,
  parameter int unsigned T_PULSE = 20,
  parameter int unsigned T_HOLD  = 3,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [1:0] op,
  input  logic [7:0] wdata,
  output logic       rdy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       verify_err,
  output logic [7:0] ayd_out,
  output logic       ayd_oe,
  input  logic [7:0] ayd_in,
  output logic       aybdir,
  output logic       aybc1,
  output logic       aybc2,
  output logic       aya8,
  output logic       aya9_n
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [1:0] OP_LATCH = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_RD    = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  // Counters load T-1 so each phase spans exactly T cycles.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);

  logic [2:0]       state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [7:0]       wdata_q, wdata_nxt;
  logic             rb_q, rb_nxt;
  logic [7:0]       rdata_nxt, dout_nxt;
  logic             verr_nxt, rdy_nxt, done_nxt, oe_nxt, bdir_nxt, bc1_nxt;
  logic             rd_cyc, active;

  assign aya8   = 1'b1;
  assign aya9_n = 1'b0;

  // Next-state and next-output logic; outputs follow the state being entered.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    op_nxt    = op_q;
    wdata_nxt = wdata_q;
    rb_nxt    = rb_q;
    rdata_nxt = rdata;
    verr_nxt  = verify_err;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (req) begin
          op_nxt    = op;
          wdata_nxt = wdata;
          rb_nxt    = 1'b0;
          verr_nxt  = 1'b0;
          if (op == OP_NOP) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SETUP;
            cnt_nxt   = SETUP_LD;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_nxt = S_STROBE;
          cnt_nxt   = PULSE_LD;
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_LD;
          if ((op_q == OP_RD) || rb_q) begin
            rdata_nxt = ayd_in;
`ifdef AY_BUS_MASTER_VERIFY_EN
            if (rb_q && (ayd_in != wdata_q)) verr_nxt = 1'b1;
`endif
          end
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_nxt = S_DONE;
`ifdef AY_BUS_MASTER_VERIFY_EN
          // A data write chains straight into a readback of the same register.
          if ((op_q == OP_WR) && !rb_q) begin
            state_nxt = S_SETUP;
            cnt_nxt   = SETUP_LD;
            rb_nxt    = 1'b1;
          end
`endif
        end else begin
          cnt_nxt = cnt_q - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    rd_cyc   = (op_nxt == OP_RD) || rb_nxt;
    active   = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) || (state_nxt == S_HOLD);
    bdir_nxt = (state_nxt == S_STROBE) && !rd_cyc;
    bc1_nxt  = (state_nxt == S_STROBE) && (rd_cyc || (op_nxt == OP_LATCH));
    oe_nxt   = active && !rd_cyc;
    dout_nxt = oe_nxt ? wdata_nxt : 8'h00;
    rdy_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
    done_nxt = (state_nxt == S_DONE);
`ifndef AY_BUS_MASTER_VERIFY_EN
    verr_nxt = 1'b0;
`endif
  end

  // State and output registers; reset releases all strobes at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_NOP;
      wdata_q    <= 8'h00;
      rb_q       <= 1'b0;
      rdy        <= 1'b1;
      done       <= 1'b0;
      rdata      <= 8'h00;
      verify_err <= 1'b0;
      ayd_out    <= 8'h00;
      ayd_oe     <= 1'b0;
      aybdir     <= 1'b0;
      aybc1      <= 1'b0;
      aybc2      <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      op_q       <= op_nxt;
      wdata_q    <= wdata_nxt;
      rb_q       <= rb_nxt;
      rdy        <= rdy_nxt;
      done       <= done_nxt;
      rdata      <= rdata_nxt;
      verify_err <= verr_nxt;
      ayd_out    <= dout_nxt;
      ayd_oe     <= oe_nxt;
      aybdir     <= bdir_nxt;
      aybc1      <= bc1_nxt;
      aybc2      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ay_bus_master.sv
// Directed bench for ay_bus_master: phase timing, strobe encodings, read capture, busy/back-to-back, reset abort.
module tb_ay_bus_master;

`ifdef AY_BUS_MASTER_VERIFY_EN
  localparam int WR_DONE = 52;
`else
  localparam int WR_DONE = 26;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req = 1'b0;
  logic [1:0] op = 2'b11;
  logic [7:0] wdata = 8'h00;
  logic [7:0] ayd_in = 8'h00;
  logic       rdy, done, verify_err, ayd_oe, aybdir, aybc1, aybc2, aya8, aya9_n;
  logic [7:0] rdata, ayd_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_rdata;

  logic       tr_done [0:63];
  logic       tr_rdy  [0:63];
  logic       tr_bdir [0:63];
  logic       tr_bc1  [0:63];
  logic       tr_oe   [0:63];
  logic       tr_verr [0:63];
  logic [7:0] tr_out  [0:63];
  logic [7:0] tr_rdata[0:63];

  int done_idx, done_cnt, st_first, st_cnt, lat_cnt, wr_cnt, rd_cnt, oe_cnt, out_bad;

  ay_bus_master dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .rdy(rdy), .done(done), .rdata(rdata), .verify_err(verify_err),
    .ayd_out(ayd_out), .ayd_oe(ayd_oe), .ayd_in(ayd_in),
    .aybdir(aybdir), .aybc1(aybc1), .aybc2(aybc2), .aya8(aya8), .aya9_n(aya9_n)
  );

  always #5 clk = ~clk;

  task automatic sample(input int i);
    tr_done[i] = done;  tr_rdy[i] = rdy;   tr_bdir[i] = aybdir; tr_bc1[i] = aybc1;
    tr_oe[i] = ayd_oe;  tr_out[i] = ayd_out; tr_rdata[i] = rdata; tr_verr[i] = verify_err;
  endtask

  // Issue one request and record n cycles; index 0 is the cycle right after the accept edge.
  task automatic run_op(input logic [1:0] o, input logic [7:0] d, input logic [7:0] rv, input int n);
    @(negedge clk); req = 1'b1; op = o; wdata = d;
    @(posedge clk); #1; req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample(i);
      ayd_in = ((i >= 3 && i <= 22) || (i >= 29 && i <= 48)) ? rv : 8'h00;
    end
    ayd_in = 8'h00;
  endtask

  task automatic stats(input int n, input logic [7:0] d);
    done_idx = -1; done_cnt = 0; st_first = -1; st_cnt = 0; lat_cnt = 0;
    wr_cnt = 0; rd_cnt = 0; oe_cnt = 0; out_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (tr_done[i]) begin done_cnt++; if (done_idx < 0) done_idx = i; end
      if (tr_bdir[i] || tr_bc1[i]) begin st_cnt++; if (st_first < 0) st_first = i; end
      if (tr_bdir[i] && tr_bc1[i]) lat_cnt++;
      if (tr_bdir[i] && !tr_bc1[i]) wr_cnt++;
      if (!tr_bdir[i] && tr_bc1[i]) rd_cnt++;
      if (tr_oe[i]) begin oe_cnt++; if (tr_out[i] !== d) out_bad++; end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++; if ({rdy, done, verify_err, ayd_oe, aybdir, aybc1, aybc2, aya8, aya9_n} !== 9'b100000110) begin
      failures++; $display("FAIL reset_ctrl: got %b want 100000110", {rdy, done, verify_err, ayd_oe, aybdir, aybc1, aybc2, aya8, aya9_n}); end
    checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata: got %h want 00", rdata); end
    checks++; if (ayd_out !== 8'h00) begin failures++; $display("FAIL reset_ayd_out: got %h want 00", ayd_out); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_rdata = 8'h00;
  endtask

  task automatic test_latch;
    run_op(2'b00, 8'h0E, 8'h00, 30);
    stats(30, 8'h0E);
    checks++; if (done_idx !== 26) begin failures++; $display("FAIL latch_done_idx: got %0d want 26", done_idx); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL latch_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (st_first !== 3) begin failures++; $display("FAIL latch_strobe_start: got %0d want 3", st_first); end
    checks++; if (lat_cnt !== 20 || st_cnt !== 20) begin failures++; $display("FAIL latch_strobe_len: got %0d/%0d want 20/20", lat_cnt, st_cnt); end
    checks++; if (oe_cnt !== 26 || tr_oe[0] !== 1'b1 || tr_oe[25] !== 1'b1) begin
      failures++; $display("FAIL latch_oe: got cnt %0d first %b last %b want 26 1 1", oe_cnt, tr_oe[0], tr_oe[25]); end
    checks++; if (out_bad !== 0) begin failures++; $display("FAIL latch_ayd_out: got %0d bad cycles want 0", out_bad); end
    checks++; if (tr_rdy[0] !== 1'b0 || tr_rdy[26] !== 1'b1) begin
      failures++; $display("FAIL latch_rdy: got %b%b want 01", tr_rdy[0], tr_rdy[26]); end
  endtask

  task automatic test_config_write;
    run_op(2'b00, 8'hF8, 8'h00, 30);
    stats(30, 8'hF8);
    checks++; if (done_idx !== 26 || lat_cnt !== 20 || st_first !== 3) begin
      failures++; $display("FAIL cfg_latch: got done %0d lat %0d start %0d want 26 20 3", done_idx, lat_cnt, st_first); end
    checks++; if (out_bad !== 0 || oe_cnt !== 26) begin failures++; $display("FAIL cfg_latch_data: got bad %0d oe %0d want 0 26", out_bad, oe_cnt); end
    run_op(2'b01, 8'h55, 8'h55, 60);
    stats(60, 8'h55);
    checks++; if (wr_cnt !== 20 || lat_cnt !== 0) begin failures++; $display("FAIL write_strobe: got wr %0d lat %0d want 20 0", wr_cnt, lat_cnt); end
    checks++; if (st_first !== 3) begin failures++; $display("FAIL write_strobe_start: got %0d want 3", st_first); end
    checks++; if (out_bad !== 0 || oe_cnt !== 26) begin failures++; $display("FAIL write_data: got bad %0d oe %0d want 0 26", out_bad, oe_cnt); end
    checks++; if (done_idx !== WR_DONE || done_cnt !== 1) begin
      failures++; $display("FAIL write_done: got idx %0d cnt %0d want %0d 1", done_idx, done_cnt, WR_DONE); end
    checks++; if (tr_verr[WR_DONE] !== 1'b0) begin failures++; $display("FAIL write_verify_err: got %b want 0", tr_verr[WR_DONE]); end
`ifdef AY_BUS_MASTER_VERIFY_EN
    exp_rdata = 8'h55;
`endif
  endtask

  task automatic test_read;
    run_op(2'b10, 8'h00, 8'hA3, 30);
    stats(30, 8'h00);
    checks++; if (oe_cnt !== 0) begin failures++; $display("FAIL read_oe: got %0d cycles want 0", oe_cnt); end
    checks++; if (rd_cnt !== 20 || st_cnt !== 20 || st_first !== 3) begin
      failures++; $display("FAIL read_strobe: got rd %0d all %0d start %0d want 20 20 3", rd_cnt, st_cnt, st_first); end
    checks++; if (done_idx !== 26) begin failures++; $display("FAIL read_done_idx: got %0d want 26", done_idx); end
    checks++; if (tr_rdata[22] !== exp_rdata || tr_rdata[23] !== 8'hA3) begin
      failures++; $display("FAIL read_capture_edge: got %h %h want %h a3", tr_rdata[22], tr_rdata[23], exp_rdata); end
    checks++; if (tr_rdata[26] !== 8'hA3) begin failures++; $display("FAIL read_rdata: got %h want a3", tr_rdata[26]); end
    exp_rdata = 8'hA3;
  endtask

  task automatic test_nop;
    run_op(2'b11, 8'h77, 8'h00, 4);
    stats(4, 8'h77);
    checks++; if (done_idx !== 0 || done_cnt !== 1 || tr_rdy[0] !== 1'b1) begin
      failures++; $display("FAIL nop_done: got idx %0d cnt %0d rdy %b want 0 1 1", done_idx, done_cnt, tr_rdy[0]); end
    checks++; if (st_cnt !== 0 || oe_cnt !== 0) begin failures++; $display("FAIL nop_bus: got strobe %0d oe %0d want 0 0", st_cnt, oe_cnt); end
    checks++; if (tr_rdata[0] !== exp_rdata) begin failures++; $display("FAIL nop_rdata: got %h want %h", tr_rdata[0], exp_rdata); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); req = 1'b1; op = 2'b00; wdata = 8'h0E;
    @(posedge clk); #1; req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      sample(i);
      if (i == 4) begin req = 1'b1; op = 2'b10; wdata = 8'h99; end
      else if (i == 5) req = 1'b0;
      else if (i == 20) begin req = 1'b1; op = 2'b00; wdata = 8'h11; end
      else if (i == 27) req = 1'b0;
    end
    stats(60, 8'h00);
    checks++; if (done_idx !== 26) begin failures++; $display("FAIL b2b_first_done: got %0d want 26", done_idx); end
    checks++; if (tr_bdir[10] !== 1'b1 || tr_bc1[10] !== 1'b1 || tr_out[10] !== 8'h0E) begin
      failures++; $display("FAIL busy_ignored: got bdir %b bc1 %b out %h want 1 1 0e", tr_bdir[10], tr_bc1[10], tr_out[10]); end
    checks++; if (tr_rdy[27] !== 1'b0 || tr_oe[27] !== 1'b1 || tr_out[27] !== 8'h11) begin
      failures++; $display("FAIL b2b_second_start: got rdy %b oe %b out %h want 0 1 11", tr_rdy[27], tr_oe[27], tr_out[27]); end
    checks++; if (done_cnt !== 2 || tr_done[53] !== 1'b1) begin
      failures++; $display("FAIL b2b_second_done: got cnt %0d done53 %b want 2 1", done_cnt, tr_done[53]); end
    checks++; if (lat_cnt !== 40 || st_cnt !== 40) begin failures++; $display("FAIL b2b_strobes: got %0d/%0d want 40/40", lat_cnt, st_cnt); end
  endtask

  task automatic test_reset_mid;
    int dones;
    @(negedge clk); req = 1'b1; op = 2'b00; wdata = 8'h3C;
    @(posedge clk); #1; req = 1'b0;
    repeat (11) @(negedge clk);
    checks++; if (aybdir !== 1'b1 || aybc1 !== 1'b1) begin failures++; $display("FAIL rstmid_pre_strobe: got %b%b want 11", aybdir, aybc1); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({rdy, done, ayd_oe, aybdir, aybc1, aybc2} !== 6'b100001) begin
      failures++; $display("FAIL rstmid_ctrl: got %b want 100001", {rdy, done, ayd_oe, aybdir, aybc1, aybc2}); end
    checks++; if (rdata !== 8'h00 || ayd_out !== 8'h00 || verify_err !== 1'b0) begin
      failures++; $display("FAIL rstmid_data: got %h %h %b want 00 00 0", rdata, ayd_out, verify_err); end
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1 || aybdir === 1'b1 || aybc1 === 1'b1) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", dones); end
    exp_rdata = 8'h00;
  endtask

`ifdef AY_BUS_MASTER_VERIFY_EN
  task automatic test_verify;
    run_op(2'b01, 8'h55, 8'h54, 60);
    stats(60, 8'h55);
    checks++; if (done_idx !== 52 || done_cnt !== 1) begin failures++; $display("FAIL verify_done: got %0d cnt %0d want 52 1", done_idx, done_cnt); end
    checks++; if (tr_rdata[52] !== 8'h54 || tr_verr[52] !== 1'b1) begin
      failures++; $display("FAIL verify_result: got rdata %h err %b want 54 1", tr_rdata[52], tr_verr[52]); end
    checks++; if (wr_cnt !== 20 || rd_cnt !== 20 || oe_cnt !== 26) begin
      failures++; $display("FAIL verify_bus: got wr %0d rd %0d oe %0d want 20 20 26", wr_cnt, rd_cnt, oe_cnt); end
    run_op(2'b11, 8'h00, 8'h00, 2);
    checks++; if (tr_verr[0] !== 1'b0) begin failures++; $display("FAIL verify_clear: got %b want 0", tr_verr[0]); end
  endtask
`endif

  initial begin
    test_reset;
    test_latch;
    test_config_write;
    test_read;
    test_nop;
    test_back_to_back;
    test_reset_mid;
`ifdef AY_BUS_MASTER_VERIFY_EN
    test_verify;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
